// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array controller: array size, FSM states, pipeline latency.
// Latency: not applicable (types and constants only); backpressure: not applicable.
package systolic_pkg;

  localparam int systolic_size_c = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } ctrl_state_t;

  // An activation entering the array edge needs 2*SIZE-1 advances to reach the output.
  function automatic int calc_lat(input int size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_perf.sv
// Saturating 32-bit busy and stall cycle counters for the MAC array controller.
// Latency: 1 cycle from event to count; backpressure: none, it only observes.
module mac_array_ctrl_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        busy_i,
  input  logic        stall_i,
  output logic [31:0] perf_busy_o,
  output logic [31:0] perf_stall_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_o  <= '0;
      perf_stall_o <= '0;
    end else if (clr_i) begin
      perf_busy_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      if (busy_i && perf_busy_o != '1)
        perf_busy_o <= perf_busy_o + 32'd1;
      if (stall_i && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for a SIZE x SIZE systolic MAC array (clear, weight load, stream, drain); MAC_ARRAY_CTRL_PERF_EN adds perf counters.
// Latency: first result 2*SIZE-1 advances after the first vector; backpressure: one output slot, the array stalls while it is full and unread.
module mac_array_ctrl
  import systolic_pkg::*;
#(
  parameter int SIZE  = systolic_size_c,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             w_valid_i,
  output logic             w_ready_o,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             arr_clr_o,
  output logic             arr_wload_o,
  output logic             arr_en_o,
  output logic             arr_bubble_o
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_busy_o,
  output logic [31:0]      perf_stall_o
`endif
);

  localparam int LAT   = calc_lat(SIZE);
  // Headroom so num_vec + LAT never wraps, even for the largest num_vec.
  localparam int ADV_W = CNT_W + $clog2(LAT + 1) + 1;
  localparam int WC_W  = $clog2(SIZE + 1);

  ctrl_state_t      state;
  logic [CNT_W-1:0] num_vec;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [ADV_W-1:0] adv_cnt;
  logic [WC_W-1:0]  w_cnt;
  logic             out_valid;

  logic             can_adv;
  logic [ADV_W-1:0] adv_lim;
  logic             w_hs;
  logic             a_hs;
  logic             drain_adv;
  logic             adv;
  logic             out_hs;
  logic             last_w;
  logic             last_in;
  logic             last_out;

  assign can_adv   = !out_valid || out_ready_i;
  assign adv_lim   = ADV_W'(num_vec) + ADV_W'(LAT - 1);
  assign w_hs      = (state == ST_LOAD_W) && w_valid_i;
  assign a_hs      = (state == ST_STREAM) && a_valid_i && can_adv;
  assign drain_adv = (state == ST_DRAIN) && can_adv && (adv_cnt < adv_lim);
  assign adv       = a_hs || drain_adv;
  assign out_hs    = out_valid && out_ready_i;
  assign last_w    = (w_cnt == WC_W'(SIZE - 1));
  assign last_in   = (in_cnt == num_vec - CNT_W'(1));
  assign last_out  = (out_cnt == num_vec - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      num_vec   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      adv_cnt   <= '0;
      w_cnt     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            num_vec <= num_vec_i;
            in_cnt  <= '0;
            out_cnt <= '0;
            adv_cnt <= '0;
            w_cnt   <= '0;
            state   <= (num_vec_i == '0) ? ST_DONE : ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_LOAD_W;
        ST_LOAD_W: begin
          if (w_hs) begin
            w_cnt <= w_cnt + WC_W'(1);
            if (last_w)
              state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (a_hs) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (last_in)
              state <= ST_DRAIN;
          end
        end
        // The last result always follows the final advance, so only DRAIN can end the job.
        ST_DRAIN: begin
          if (out_hs && last_out)
            state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (adv)
        adv_cnt <= adv_cnt + ADV_W'(1);
      if (out_hs)
        out_cnt <= out_cnt + CNT_W'(1);

      if (adv && (adv_cnt >= ADV_W'(LAT - 1)))
        out_valid <= 1'b1;
      else if (out_hs)
        out_valid <= 1'b0;
    end
  end

  assign busy_o       = (state != ST_IDLE);
  assign done_o       = (state == ST_DONE);
  assign w_ready_o    = (state == ST_LOAD_W);
  assign arr_wload_o  = w_hs;
  assign a_ready_o    = (state == ST_STREAM) && can_adv;
  assign arr_en_o     = adv;
  assign arr_bubble_o = drain_adv;
  assign arr_clr_o    = (state == ST_CLEAR);
  assign out_valid_o  = out_valid;

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic perf_stall;
  logic perf_clr;

  assign perf_stall = ((state == ST_STREAM) || (state == ST_DRAIN)) && !can_adv;
  assign perf_clr   = (state == ST_IDLE) && start_i;

  mac_array_ctrl_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (perf_clr),
    .busy_i       (busy_o),
    .stall_i      (perf_stall),
    .perf_busy_o  (perf_busy_o),
    .perf_stall_o (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl (SIZE=4); perf counter checks only when MAC_ARRAY_CTRL_PERF_EN is defined.
// Each job is replayed cycle by cycle and compared against hand-derived timelines.
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] num_vec_i = '0;
  logic        busy_o, done_o;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o;
  logic        a_valid_i = 1'b0;
  logic        a_ready_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        arr_clr_o, arr_wload_o, arr_en_o, arr_bubble_o;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_busy_o, perf_stall_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle snapshot: {clr, wload, en, bubble, out_valid, done, busy, a_ready}
  logic [7:0] trace [64];

  mac_array_ctrl #(.SIZE(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .num_vec_i    (num_vec_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .a_valid_i    (a_valid_i),
    .a_ready_o    (a_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .arr_clr_o    (arr_clr_o),
    .arr_wload_o  (arr_wload_o),
    .arr_en_o     (arr_en_o),
    .arr_bubble_o (arr_bubble_o)
`ifdef MAC_ARRAY_CTRL_PERF_EN
    ,
    .perf_busy_o  (perf_busy_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] snap();
    return {arr_clr_o, arr_wload_o, arr_en_o, arr_bubble_o, out_valid_o, done_o, busy_o, a_ready_o};
  endfunction

  // Drives one job from cycle 0 (start pulse) and gathers per-cycle statistics.
  task automatic run_job(input int nv, input int stall_from, input int stall_len,
                         input int start_at, input bit gap_w, input int rst_at,
                         output int done_cyc, output int hs, output int wl, output int clr_n,
                         output int adv, output int bub, output int ovl);
    done_cyc = -1; hs = 0; wl = 0; clr_n = 0; adv = 0; bub = 0; ovl = 0;
    for (int i = 0; i < 64; i++) trace[i] = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start_i     = (cyc == 0) || (cyc == start_at);
      num_vec_i   = (cyc == 0) ? 16'(nv) : 16'd7;
      w_valid_i   = gap_w ? cyc[0] : 1'b1;
      a_valid_i   = 1'b1;
      out_ready_i = !((cyc >= stall_from) && (cyc < stall_from + stall_len));
      if (cyc == rst_at) rst_n = 1'b0;
      #1;
      trace[cyc] = snap();
      if (done_o && done_cyc < 0) done_cyc = cyc;
      if (out_valid_o && out_ready_i) hs++;
      if (arr_wload_o) wl++;
      if (arr_clr_o) clr_n++;
      if (arr_en_o) adv++;
      if (arr_bubble_o) bub++;
      if (int'(arr_clr_o) + int'(arr_wload_o) + int'(arr_en_o) > 1) ovl++;
      if (cyc == rst_at) break;
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b1;
    num_vec_i = 16'd3;
    @(negedge clk); #1;
    vectors++;
    if ({snap(), w_ready_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, need %b", {snap(), w_ready_o}, 9'b0);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (snap() !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b, need %b", snap(), 8'b0);
    end
  endtask

  task automatic test_basic();
    int d, hs, wl, cl, ad, bb, ov;
    logic [7:0] exp;
    run_job(3, 0, 0, -1, 1'b0, -1, d, hs, wl, cl, ad, bb, ov);
    for (int c = 0; c <= 17; c++) begin
      exp = (c == 0)  ? 8'b00000000 :
            (c == 1)  ? 8'b10000010 :
            (c <= 5)  ? 8'b01000010 :
            (c <= 8)  ? 8'b00100011 :
            (c <= 12) ? 8'b00110010 :
            (c <= 14) ? 8'b00111010 :
            (c == 15) ? 8'b00001010 :
            (c == 16) ? 8'b00000110 : 8'b00000000;
      vectors++;
      if (trace[c] !== exp) begin
        miscompares++;
        $display("FAIL basic_cycle%0d: got %b, need %b", c, trace[c], exp);
      end
    end
    vectors++;
    if ({d, hs, wl, cl, ad, bb, ov} !== {32'sd16, 32'sd3, 32'sd4, 32'sd1, 32'sd9, 32'sd6, 32'sd0}) begin
      miscompares++;
      $display("FAIL basic_totals: done@%0d hs=%0d wl=%0d clr=%0d adv=%0d bub=%0d ovl=%0d, need 16 3 4 1 9 6 0",
               d, hs, wl, cl, ad, bb, ov);
    end
  endtask

  task automatic test_zero_job();
    int d, hs, wl, cl, ad, bb, ov;
    run_job(0, 0, 0, -1, 1'b0, -1, d, hs, wl, cl, ad, bb, ov);
    vectors++;
    if (trace[1] !== 8'b00000110) begin
      miscompares++;
      $display("FAIL zero_done_cycle: got %b, need %b", trace[1], 8'b00000110);
    end
    vectors++;
    if ({d, hs, wl, cl, ad} !== {32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0}) begin
      miscompares++;
      $display("FAIL zero_totals: done@%0d hs=%0d wl=%0d clr=%0d adv=%0d, need 1 0 0 0 0", d, hs, wl, cl, ad);
    end
  endtask

  task automatic test_stall();
    int d, hs, wl, cl, ad, bb, ov;
    run_job(10, 13, 5, -1, 1'b0, -1, d, hs, wl, cl, ad, bb, ov);
    for (int c = 13; c <= 17; c++) begin
      vectors++;
      if (trace[c] !== 8'b00001010) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got %b, need %b", c, trace[c], 8'b00001010);
      end
    end
    vectors++;
    if (trace[18] !== 8'b00101011) begin
      miscompares++;
      $display("FAIL stall_resume: got %b, need %b", trace[18], 8'b00101011);
    end
    vectors++;
    if ({d, hs, ad, ov} !== {32'sd28, 32'sd10, 32'sd16, 32'sd0}) begin
      miscompares++;
      $display("FAIL stall_totals: done@%0d hs=%0d adv=%0d ovl=%0d, need 28 10 16 0", d, hs, ad, ov);
    end
`ifdef MAC_ARRAY_CTRL_PERF_EN
    vectors++;
    if (perf_stall_o !== 32'd5) begin
      miscompares++;
      $display("FAIL perf_stall: got %0d, need 5", perf_stall_o);
    end
    vectors++;
    if (perf_busy_o !== 32'd28) begin
      miscompares++;
      $display("FAIL perf_busy: got %0d, need 28", perf_busy_o);
    end
`endif
  endtask

  task automatic test_reset_in_drain();
    int d, hs, wl, cl, ad, bb, ov;
    run_job(3, 0, 0, -1, 1'b0, 10, d, hs, wl, cl, ad, bb, ov);
    vectors++;
    if (trace[10] !== 8'b0 || d != -1) begin
      miscompares++;
      $display("FAIL drain_reset_now: got %b done@%0d, need %b done@-1", trace[10], d, 8'b0);
    end
    @(negedge clk); #1;
    vectors++;
    if (snap() !== 8'b0) begin
      miscompares++;
      $display("FAIL drain_reset_hold: got %b, need %b", snap(), 8'b0);
    end
    rst_n = 1'b1;
    run_job(2, 0, 0, -1, 1'b0, -1, d, hs, wl, cl, ad, bb, ov);
    vectors++;
    if ({d, hs, ad, cl} !== {32'sd15, 32'sd2, 32'sd8, 32'sd1}) begin
      miscompares++;
      $display("FAIL after_reset_job: done@%0d hs=%0d adv=%0d clr=%0d, need 15 2 8 1", d, hs, ad, cl);
    end
  endtask

  task automatic test_start_in_stream();
    int d, hs, wl, cl, ad, bb, ov;
    run_job(3, 0, 0, 7, 1'b0, -1, d, hs, wl, cl, ad, bb, ov);
    vectors++;
    if ({d, hs, ad, bb} !== {32'sd16, 32'sd3, 32'sd9, 32'sd6}) begin
      miscompares++;
      $display("FAIL start_ignored: done@%0d hs=%0d adv=%0d bub=%0d, need 16 3 9 6", d, hs, ad, bb);
    end
  endtask

  task automatic test_gapped_weights();
    int d, hs, wl, cl, ad, bb, ov;
    run_job(1, 0, 0, -1, 1'b1, -1, d, hs, wl, cl, ad, bb, ov);
    vectors++;
    if (wl != 4 || ov != 0) begin
      miscompares++;
      $display("FAIL gapped_wload: wl=%0d ovl=%0d, need 4 0", wl, ov);
    end
    vectors++;
    if ({d, hs, ad} !== {32'sd18, 32'sd1, 32'sd7}) begin
      miscompares++;
      $display("FAIL gapped_totals: done@%0d hs=%0d adv=%0d, need 18 1 7", d, hs, ad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_job();
    test_stall();
    test_reset_in_drain();
    test_start_in_stream();
    test_gapped_weights();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default systolic_size_c (4); meaning: array is SIZE x SIZE.
REQ-002 SHALL have parameter CNT_W, default 16; meaning: width of vector count.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as follows:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have the following job-control ports:
- start_i  in  1  job start pulse.
- num_vec_i  in  CNT_W  activation vectors in job; sampled at start.
- busy_o  out  1  job in progress (state != IDLE).
- done_o  out  1  one-cycle job-complete pulse.
REQ-005 SHALL have the following weight-load ports:
- w_valid_i  in  1  weight row offered.
- w_ready_o  out  1  weight row accepted.
REQ-006 SHALL have the following activation and result ports:
- a_valid_i  in  1  activation vector offered.
- a_ready_o  out  1  activation vector accepted.
- out_valid_o  out  1  result vector at array output is pending.
- out_ready_i  in  1  downstream accepts result.
REQ-007 SHALL have the following array-control ports:
- arr_clr_o  out  1  clear accumulators.
- arr_wload_o  out  1  shift one weight row into array.
- arr_en_o  out  1  advance array one step.
- arr_bubble_o  out  1  inject zeros on this advance.

Function
REQ-008 SHALL implement states IDLE, CLEAR, LOAD_W, STREAM, DRAIN, DONE.
REQ-009 IDLE: start_i with num_vec_i != 0 -> CLEAR; with num_vec_i == 0 -> DONE; start_i outside IDLE SHALL be ignored.
REQ-010 CLEAR: arr_clr_o=1 for exactly one cycle -> LOAD_W.
REQ-011 LOAD_W: w_ready_o=1; arr_wload_o = w_valid_i & w_ready_o; after the SIZE-th weight handshake -> STREAM.
REQ-012 Define LAT = 2*SIZE-1; an advance is any cycle with arr_en_o=1; adv_cnt counts advances per job.
REQ-013 Array SHALL advance only if !out_valid_o || out_ready_i (one-slot output, no skid).
REQ-014 STREAM: a_ready_o = !out_valid_o || out_ready_i; arr_en_o = a_valid_i & a_ready_o; after the num_vec-th accepted vector -> DRAIN.
REQ-015 DRAIN: arr_en_o=arr_bubble_o=1 whenever REQ-013 holds and adv_cnt < num_vec+LAT-1; a_ready_o=0.
REQ-016 out_valid_o SHALL be registered:
- set on any advance that makes adv_cnt >= LAT;
- cleared on handshake when no such advance occurs in the same cycle;
- SHALL NOT depend combinationally on out_ready_i.
REQ-017 Result index = adv_cnt-LAT; exactly num_vec results per job, strictly in order.
REQ-018 After the num_vec-th output handshake -> DONE; DONE: done_o=1 for one cycle -> IDLE.
REQ-019 arr_en_o, arr_wload_o and arr_clr_o SHALL never be asserted in the same cycle.
REQ-020 Counters SHALL be wide enough for num_vec+LAT with no wrap; num_vec_i = 2^CNT_W-1 SHALL be legal.

Reset
REQ-021 Reset SHALL force IDLE, all counters 0, and all outputs 0, including mid-job; no done_o SHALL follow an aborted job.

Configuration
REQ-022 With MAC_ARRAY_CTRL_PERF_EN defined, the block SHALL add outputs perf_busy_o[31:0] and perf_stall_o[31:0]:
- perf_busy_o counts cycles with busy_o=1;
- perf_stall_o counts STREAM/DRAIN cycles where REQ-013 blocks an advance;
- both saturate at max and clear on start.
REQ-023 Without the macro, those ports and counters SHALL be absent.

Structure
REQ-024 Package systolic_pkg SHALL hold systolic_size_c, the state enum ctrl_state_t, and the LAT derivation.
REQ-025 Perf counters SHALL live in sub-module mac_array_ctrl_perf, instantiated only under the macro.

Verification
REQ-026 SIZE=4, num_vec=3, all valid/ready high:
- clr in 1 cycle, then 4 wload cycles;
- 9 advances, of which the last 6 are bubbles;
- out_valid_o asserted after advances 7, 8, 9;
- done_o 1 cycle after the 3rd result.
REQ-027 num_vec=0 start -> done_o next cycle; no arr_* assertion.
REQ-028 out_ready_i low 5 cycles with a result pending:
- arr_en_o and a_ready_o stay 0 throughout;
- perf_stall_o increments by 5;
- no result lost or duplicated.
REQ-029 rst_n low during DRAIN -> IDLE immediately; a following num_vec=2 job completes normally.
REQ-030 start_i pulsed during STREAM -> ignored; num_vec is unchanged.
REQ-031 w_valid_i gapped (1 of every 2 cycles) -> exactly 4 arr_wload_o pulses before STREAM.
